axis_bram_reader: RTL and testbench

//  Downstream of the capture DAQ: reads a finished capture out of BRAM port B and streams it on
//  AXI-Stream master (to DMA/FIFO). Started by PS/DAQ-done pulse; sign-extends 16b samples;

---
 rtl/axis_bram_reader.sv | 214 +++++++++++++++++++++
 tb/tb_axis_bram_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_reader.sv
// ---------------------------------------------------------------------------
// axis_bram_reader
//
// Streams a finished capture out of BRAM port B onto an AXI-Stream master.
// A start pulse latches a start address and a word count. Reads are issued
// back-to-back into a pipelined BRAM. Returning samples land in a small skid
// FIFO, which absorbs arbitrary tready backpressure. Each sample is
// sign-extended to the stream width. A transfer ends after the requested
// number of beats, or earlier on a delimiter sample (0x7FFF) when DELIM_STOP
// is set.
//
// Ports
//   aclk, areset        clock and synchronous active-high reset
//   start_i             one-cycle start pulse, honoured only when idle
//   start_addr_i        first BRAM address, sampled with start_i
//   length_i            number of words to read, sampled with start_i
//   busy_o              high while a transfer is reading or draining
//   done_o              one-cycle pulse after the final beat is accepted
//   words_sent_o        beats accepted in the current or last transfer
//   bram_portb_*        BRAM read port (clk, addr, en, rddata)
//   m_axis_*            AXI-Stream master (tdata, tvalid, tready, tlast)
// ---------------------------------------------------------------------------
module axis_bram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 16,
  parameter int BRAM_ADDR_WIDTH  = 16,
  parameter int BRAM_RD_LATENCY  = 2,
  parameter int DELIM_STOP       = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]  start_addr_i,
  input  logic [BRAM_ADDR_WIDTH:0]    length_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [BRAM_ADDR_WIDTH:0]    words_sent_o,
  output logic                        bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  output logic                        bram_portb_en,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam int FIFO_DEPTH = BRAM_RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BRAM_DATA_WIDTH-1:0] DELIM_WORD = BRAM_DATA_WIDTH'(16'h7FFF);

  logic [1:0]                   state;
  logic [BRAM_ADDR_WIDTH:0]     len_q;
  logic [BRAM_ADDR_WIDTH:0]     issued;
  logic [BRAM_ADDR_WIDTH-1:0]   next_addr;
  logic                         delim_seen;
  logic [BRAM_RD_LATENCY-1:0]   rd_pipe;
  logic [CNT_W-1:0]             outstanding;

  logic [BRAM_DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_count;

  logic                         start_ok;
  logic                         first_issue;
  logic                         issue_next;
  logic [BRAM_ADDR_WIDTH-1:0]   issue_addr;
  logic                         capture;
  logic                         capture_delim;
  logic                         pop;
  logic                         last_beat;
  logic                         last_accept;
  logic                         head_is_delim;
  logic [BRAM_DATA_WIDTH-1:0]   head;
  logic                         credit_ok;

  assign bram_portb_clk = aclk;

  assign busy_o = (state == S_READ) || (state == S_DRAIN);
  assign done_o = (state == S_DONE);

  // Outputs come straight from the FIFO head and the beat counter. Both only
  // change on an accepted beat, so the beat stays stable while stalled.
  assign head          = fifo_mem[rd_ptr];
  assign m_axis_tvalid = (fifo_count != '0);
  assign head_is_delim = (DELIM_STOP != 0) && (head == DELIM_WORD);
  assign last_beat     = ((words_sent_o + (BRAM_ADDR_WIDTH+1)'(1)) == len_q) || head_is_delim;
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign m_axis_tdata  = m_axis_tvalid ? AXIS_TDATA_WIDTH'($signed(head)) : '0;

  assign pop         = m_axis_tvalid && m_axis_tready;
  assign last_accept = pop && last_beat;

  // A read slot is free when the words already owed to the FIFO (queued,
  // in the BRAM pipe, or issued this cycle), minus the one leaving now,
  // leave room. This guarantees returning data always has a home.
  assign credit_ok   = (outstanding - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
  assign start_ok    = (state == S_IDLE) && start_i;
  assign first_issue = start_ok && (length_i != '0);
  assign issue_next  = first_issue ||
                       ((state == S_READ) && !last_accept && (issued != len_q) &&
                        !delim_seen && credit_ok);
  assign issue_addr  = first_issue ? start_addr_i : next_addr;

  assign capture       = rd_pipe[BRAM_RD_LATENCY-1];
  assign capture_delim = (DELIM_STOP != 0) && (bram_portb_rddata == DELIM_WORD);

  // Control FSM, read address generation and transfer bookkeeping.
  // next_addr holds the address of the following read and wraps naturally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= S_IDLE;
      len_q           <= '0;
      issued          <= '0;
      next_addr       <= '0;
      bram_portb_addr <= '0;
      bram_portb_en   <= 1'b0;
      words_sent_o    <= '0;
      delim_seen      <= 1'b0;
    end else begin
      bram_portb_en <= issue_next;
      if (issue_next) begin
        bram_portb_addr <= issue_addr;
        next_addr       <= issue_addr + BRAM_ADDR_WIDTH'(1);
        issued          <= first_issue ? (BRAM_ADDR_WIDTH+1)'(1)
                                       : issued + (BRAM_ADDR_WIDTH+1)'(1);
      end

      if (start_ok) begin
        len_q        <= length_i;
        words_sent_o <= '0;
        delim_seen   <= 1'b0;
      end else begin
        if (pop) begin
          words_sent_o <= words_sent_o + (BRAM_ADDR_WIDTH+1)'(1);
        end
        if (capture && capture_delim) begin
          delim_seen <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            state <= (length_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (last_accept) begin
            state <= S_DONE;
          end else if ((issued == len_q) || delim_seen) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_accept) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The BRAM pipe tracks which cycles carry valid read data. The outstanding
  // counter is the credit pool. Both are flushed when the final beat goes
  // out, so reads still in flight after a delimiter are silently dropped.
  always_ff @(posedge aclk) begin
    if (areset || last_accept) begin
      rd_pipe     <= '0;
      outstanding <= '0;
    end else begin
      rd_pipe     <= (rd_pipe << 1) | BRAM_RD_LATENCY'(bram_portb_en);
      outstanding <= outstanding + CNT_W'(issue_next) - CNT_W'(pop);
    end
  end

  // Skid FIFO pointers and occupancy. Depth is not necessarily a power of
  // two, so the pointers wrap explicitly.
  always_ff @(posedge aclk) begin
    if (areset || last_accept) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(capture) - CNT_W'(pop);
    end
  end

  // FIFO storage. It needs no reset because tdata is masked whenever the
  // FIFO is empty.
  always_ff @(posedge aclk) begin
    if (capture) begin
      fifo_mem[wr_ptr] <= bram_portb_rddata;
    end
  end

endmodule

// File: tb/tb_axis_bram_reader.sv
// ---------------------------------------------------------------------------
// tb_axis_bram_reader
//
// Self-checking bench for axis_bram_reader. A behavioural BRAM with a
// two-cycle read latency feeds the DUT. The expected beat list for every
// transfer is computed from the memory contents:
//   - words are read from consecutive addresses, modulo 2**16;
//   - each word is sign-extended;
//   - the list ends after the requested length or on the first 0x7FFF.
// One monitor process compares every accepted beat against that list and
// also checks that stalled beats stay stable.
// ---------------------------------------------------------------------------
module tb_axis_bram_reader;

  localparam int LAT = 2;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        aclk;
  logic        areset;
  logic        start_i;
  logic [15:0] start_addr_i;
  logic [16:0] length_i;
  logic        busy_o;
  logic        done_o;
  logic [16:0] words_sent_o;
  logic        bram_portb_clk;
  logic [15:0] bram_portb_addr;
  logic        bram_portb_en;
  logic [15:0] bram_portb_rddata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          readyPct = 100;
  int          expCount;
  int          doneCount = 0;
  int          doneCyc = -1;
  int          firstValidCyc = -1;
  int          firstAcceptCyc = -1;
  int          lastAcceptCyc = -1;
  int          beatsAcc = 0;
  int          startCyc;
  logic [31:0] firstAcceptData;
  logic [31:0] lastAcceptData;
  logic        stalledPrev = 1'b0;
  logic [31:0] prevD;
  logic        prevL;
  beat_t       monB;
  beat_t       expq[$];
  logic [15:0] mem [0:65535];
  logic [15:0] a1, a2;
  logic        recAddrs = 1'b0;
  logic [15:0] rdAddrs[$];

  axis_bram_reader #(
    .AXIS_TDATA_WIDTH(32),
    .BRAM_DATA_WIDTH (16),
    .BRAM_ADDR_WIDTH (16),
    .BRAM_RD_LATENCY (LAT),
    .DELIM_STOP      (1)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .start_i          (start_i),
    .start_addr_i     (start_addr_i),
    .length_i         (length_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .words_sent_o     (words_sent_o),
    .bram_portb_clk   (bram_portb_clk),
    .bram_portb_addr  (bram_portb_addr),
    .bram_portb_en    (bram_portb_en),
    .bram_portb_rddata(bram_portb_rddata),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast)
  );

  // Free-running clock and cycle counter.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc++;

  // Behavioural BRAM: the address registered with en appears as data two
  // cycles later.
  always @(posedge aclk) begin
    a1 <= bram_portb_addr;
    a2 <= a1;
    if (bram_portb_en && recAddrs) rdAddrs.push_back(bram_portb_addr);
  end

  assign bram_portb_rddata = mem[a2];

  // Sink readiness is redrawn each cycle, shortly after the active edge.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = ($urandom_range(0, 99) < readyPct);
    end
  end

  // Compare process. It scores every accepted beat against the expected
  // list, checks that stalled beats hold, and records timing marks.
  always @(negedge aclk) begin
    if (areset) begin
      stalledPrev = 1'b0;
    end else begin
      if (done_o) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (stalledPrev) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prevD || m_axis_tlast !== prevL) begin
          failures++;
          $display("[TB] FAIL stable_while_stalled: got valid=%0b data=0x%08h last=%0b, need valid=1 data=0x%08h last=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prevD, prevL);
        end
      end
      if (m_axis_tvalid && firstValidCyc < 0) firstValidCyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("[TB] FAIL extra_beat: got data=0x%08h last=%0b, need no beat",
                   m_axis_tdata, m_axis_tlast);
        end else begin
          monB = expq.pop_front();
          if (m_axis_tdata !== monB.d || m_axis_tlast !== monB.l) begin
            failures++;
            $display("[TB] FAIL beat_%0d: got data=0x%08h last=%0b, need data=0x%08h last=%0b",
                     beatsAcc, m_axis_tdata, m_axis_tlast, monB.d, monB.l);
          end
        end
        if (firstAcceptCyc < 0) begin
          firstAcceptCyc  = cyc;
          firstAcceptData = m_axis_tdata;
        end
        lastAcceptCyc  = cyc;
        lastAcceptData = m_axis_tdata;
        beatsAcc++;
      end
      stalledPrev = m_axis_tvalid && !m_axis_tready;
      prevD       = m_axis_tdata;
      prevL       = m_axis_tlast;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), need %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Reference model: the beat list a transfer must produce.
  task automatic buildExpect(input logic [15:0] addr, input int len);
    logic [15:0] a;
    logic [15:0] w;
    beat_t       b;
    expq.delete();
    expCount = 0;
    for (int i = 0; i < len; i++) begin
      a   = addr + 16'(i);
      w   = mem[a];
      b.d = {{16{w[15]}}, w};
      b.l = (i == len - 1) || (w == 16'h7FFF);
      expq.push_back(b);
      expCount++;
      if (b.l) break;
    end
  endtask

  // Runs one transfer to completion and applies the checks common to all.
  // With pokeBusy set, it also pulses a conflicting start mid-transfer.
  task automatic applyStimulus(input logic [15:0] addr, input int len, input int pct,
                               input bit pokeBusy);
    int n;
    int d0;
    bit got;
    readyPct = pct;
    buildExpect(addr, len);
    firstValidCyc  = -1;
    firstAcceptCyc = -1;
    lastAcceptCyc  = -1;
    beatsAcc       = 0;
    d0             = doneCount;
    @(posedge aclk);
    #1;
    start_i      = 1'b1;
    start_addr_i = addr;
    length_i     = 17'(len);
    startCyc     = cyc;
    @(posedge aclk);
    #1;
    start_i      = 1'b0;
    start_addr_i = 16'($urandom);
    length_i     = 17'($urandom);
    n   = 0;
    got = 1'b0;
    while (!got && n < 4000) begin
      @(posedge aclk);
      #2;
      n++;
      if (pokeBusy && n == 3) begin
        checkOutput("busy_during_xfer", busy_o, 1);
        start_i      = 1'b1;
        start_addr_i = 16'h3000;
        length_i     = 17'd5;
      end
      if (pokeBusy && n == 4) start_i = 1'b0;
      if (doneCount != d0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done_o within %0d cycles, need one", n);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      expq.delete();
      return;
    end
    checkOutput("words_sent", words_sent_o, expCount);
    checkOutput("beats_left", expq.size(), 0);
    if (expCount == 0) begin
      checkOutput("done_delay_len0", doneCyc - startCyc, 1);
      checkOutput("no_tvalid_len0", firstValidCyc, -1);
    end else begin
      checkOutput("done_after_last", doneCyc - lastAcceptCyc, 1);
    end
    @(negedge aclk);
    #1;
    checkOutput("done_pulse_width", done_o, 0);
    checkOutput("busy_after_done", busy_o, 0);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got simulation still running, need completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] wrapExp [4];
    logic [15:0] ra;
    int          rl;
    int          pct;
    int          n;
    int          d0;

    wrapExp[0] = 16'hFFFE;
    wrapExp[1] = 16'hFFFF;
    wrapExp[2] = 16'h0000;
    wrapExp[3] = 16'h0001;

    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w == 16'h7FFF) w = 16'h1234;
      mem[i] = w;
    end

    areset       = 1'b1;
    start_i      = 1'b0;
    start_addr_i = '0;
    length_i     = '0;
    readyPct     = 100;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_busy",   busy_o, 0);
    checkOutput("rst_done",   done_o, 0);
    checkOutput("rst_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_tlast",  m_axis_tlast, 0);
    checkOutput("rst_tdata",  m_axis_tdata, 0);
    checkOutput("rst_en",     bram_portb_en, 0);
    checkOutput("rst_addr",   bram_portb_addr, 0);
    checkOutput("rst_words",  words_sent_o, 0);
    areset = 1'b0;

    // Basic run at full rate: latency, throughput and literal data.
    for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 16'h0100 + 16'(i);
    applyStimulus(16'h0010, 8, 100, 1'b0);
    checkOutput("basic_exp_count", expCount, 8);
    checkOutput("basic_first_data", firstAcceptData, 32'h0000_0100);
    checkOutput("basic_last_data", lastAcceptData, 32'h0000_0107);
    checkOutput("basic_words", words_sent_o, 8);
    checkOutput("basic_latency", firstValidCyc - startCyc, LAT + 2);
    checkOutput("basic_full_rate", lastAcceptCyc - firstAcceptCyc, 7);

    // Backpressure with a start pulse while busy that must be ignored.
    applyStimulus(16'h0200, 16, 30, 1'b1);
    checkOutput("bp_words", words_sent_o, 16);

    // Address wrap from all-ones to zero.
    mem[16'hFFFE] = 16'h0AAE;
    mem[16'hFFFF] = 16'h0AAF;
    mem[16'h0000] = 16'h0AA0;
    mem[16'h0001] = 16'h0AA1;
    rdAddrs.delete();
    recAddrs = 1'b1;
    applyStimulus(16'hFFFE, 4, 100, 1'b0);
    recAddrs = 1'b0;
    checkOutput("wrap_reads", rdAddrs.size(), 4);
    for (int i = 0; i < 4 && i < rdAddrs.size(); i++) begin
      checkOutput($sformatf("wrap_addr%0d", i), rdAddrs[i], wrapExp[i]);
    end
    checkOutput("wrap_last_data", lastAcceptData, 32'h0000_0AA1);

    // Delimiter at address 5 cuts a 32-word request to 6 beats.
    mem[5] = 16'h7FFF;
    applyStimulus(16'h0000, 32, 100, 1'b0);
    checkOutput("delim_exp_count", expCount, 6);
    checkOutput("delim_words", words_sent_o, 6);
    checkOutput("delim_last_data", lastAcceptData, 32'h0000_7FFF);

    // Negative sample sign extension.
    mem[16'h0040] = 16'h8001;
    applyStimulus(16'h0040, 1, 100, 1'b0);
    checkOutput("sext_data", lastAcceptData, 32'hFFFF_8001);

    // Zero-length request: no beats, done_o on the next cycle.
    applyStimulus(16'h0050, 0, 100, 1'b0);

    // Reset in the middle of a 10-word transfer.
    readyPct = 100;
    buildExpect(16'h0400, 10);
    beatsAcc = 0;
    @(posedge aclk);
    #1;
    start_i      = 1'b1;
    start_addr_i = 16'h0400;
    length_i     = 17'd10;
    @(posedge aclk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (beatsAcc < 3 && n < 200) begin
      @(posedge aclk);
      #2;
      n++;
    end
    checkOutput("reached_beat3", (beatsAcc >= 3) ? 1 : 0, 1);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    checkOutput("mid_rst_tvalid", m_axis_tvalid, 0);
    checkOutput("mid_rst_busy",   busy_o, 0);
    checkOutput("mid_rst_done",   done_o, 0);
    checkOutput("mid_rst_en",     bram_portb_en, 0);
    checkOutput("mid_rst_words",  words_sent_o, 0);
    areset = 1'b0;
    expq.delete();
    d0 = doneCount;
    repeat (20) @(posedge aclk);
    #2;
    checkOutput("no_done_after_rst", doneCount - d0, 0);
    checkOutput("idle_tvalid", m_axis_tvalid, 0);

    // Randomised transfers, some with a planted delimiter.
    for (int t = 0; t < 20; t++) begin
      ra = 16'($urandom);
      rl = $urandom_range(1, 40);
      case ($urandom_range(0, 2))
        0:       pct = 100;
        1:       pct = 70;
        default: pct = 30;
      endcase
      if ($urandom_range(0, 2) == 0) mem[ra + 16'($urandom_range(0, rl - 1))] = 16'h7FFF;
      applyStimulus(ra, rl, pct, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
